hci_l2_bank_arbiter: RTL and testbench

HCI_L2_BANK_ARBITER -- requirements
Module: hci_l2_bank_arbiter

---
 rtl/hci_l2_bank_arbiter.sv | 163 ++++++++++++++++
 tb/tb_hci_l2_bank_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hci_l2_bank_arbiter.sv
// N-to-1 L2 bank arbiter: CH0 group priority or flat round-robin, zero-latency request path, MEM_LAT response pipe.
// Optional macro HCI_L2_ARB_STARVE_EN adds a CH1 starvation counter; backpressure via mem_gnt_i gating all grants.
module hci_l2_bank_arbiter #(
  parameter int N_CH0      = 4,
  parameter int N_CH1      = 2,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int BW         = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 8,
  localparam int N         = N_CH0 + N_CH1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          arb_policy_i,
  input  logic [N-1:0]                  in_req_i,
  input  logic [N-1:0]                  in_wen_i,
  input  logic [N-1:0][AW-1:0]          in_add_i,
  input  logic [N-1:0][DW-1:0]          in_data_i,
  input  logic [N-1:0][DW/BW-1:0]       in_be_i,
  output logic [N-1:0]                  in_gnt_o,
  output logic [N-1:0]                  in_r_valid_o,
  output logic [N-1:0][DW-1:0]          in_r_data_o,
  output logic                          mem_req_o,
  output logic                          mem_wen_o,
  output logic [AW-1:0]                 mem_add_o,
  output logic [DW-1:0]                 mem_data_o,
  output logic [DW/BW-1:0]              mem_be_o,
  input  logic                          mem_gnt_i,
  input  logic [DW-1:0]                 mem_r_data_i
);

  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int P0W = (N_CH0 > 1) ? $clog2(N_CH0) : 1;
  localparam int P1W = (N_CH1 > 1) ? $clog2(N_CH1) : 1;

  logic [P0W-1:0]              r_p0;
  logic [P1W-1:0]              r_p1;
  logic [IW-1:0]               r_pg;
  logic [MEM_LAT-1:0]          r_pv;
  logic [MEM_LAT-1:0][IW-1:0]  r_pi;

  logic [IW-1:0]  w_j;
  logic [IW-1:0]  w_pick0;
  logic [IW-1:0]  w_pick1;
  logic [IW-1:0]  w_pickg;
  logic [IW-1:0]  w_win;
  logic [IW-1:0]  w_off1;
  logic [P0W-1:0] w_nxt0;
  logic [P1W-1:0] w_nxt1;
  logic [IW-1:0]  w_nxtg;
  logic           w_any0;
  logic           w_any1;
  logic           w_win_ch1;
  logic           w_acc;
  logic           w_force1;

  assign w_any0    = |in_req_i[N_CH0-1:0];
  assign w_any1    = |in_req_i[N-1:N_CH0];
  assign mem_req_o = |in_req_i;
  assign w_acc     = mem_req_o & mem_gnt_i;

  // Scan from the pointer downwards so the last hit (k == 0 side) is the first requester at or after it.
  always_comb begin
    w_j     = '0;
    w_pick0 = '0;
    w_pick1 = IW'(N_CH0);
    w_pickg = '0;
    for (int k = N_CH0 - 1; k >= 0; k--) begin
      w_j = IW'((int'(r_p0) + k) % N_CH0);
      if (in_req_i[w_j]) w_pick0 = w_j;
    end
    for (int k = N_CH1 - 1; k >= 0; k--) begin
      w_j = IW'(N_CH0 + (int'(r_p1) + k) % N_CH1);
      if (in_req_i[w_j]) w_pick1 = w_j;
    end
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(r_pg) + k) % N);
      if (in_req_i[w_j]) w_pickg = w_j;
    end
  end

`ifdef HCI_L2_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] r_sc;

  assign w_force1 = (r_sc == SW'(STARVE_MAX));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sc <= '0;
    end else if (arb_policy_i || !w_any1) begin
      r_sc <= '0;
    end else if (w_acc) begin
      if (w_win_ch1)                     r_sc <= '0;
      else if (r_sc != SW'(STARVE_MAX))  r_sc <= r_sc + 1'b1;
    end
  end
`else
  assign w_force1 = 1'b0;
`endif

  always_comb begin
    w_win = w_pick0;
    if (arb_policy_i)                           w_win = w_pickg;
    else if (w_any1 && (!w_any0 || w_force1))   w_win = w_pick1;
  end

  assign w_win_ch1 = (w_win >= IW'(N_CH0));
  assign w_off1    = w_win - IW'(N_CH0);
  assign w_nxt0    = (w_win  == IW'(N_CH0 - 1)) ? '0 : P0W'(w_win + IW'(1));
  assign w_nxt1    = (w_off1 == IW'(N_CH1 - 1)) ? '0 : P1W'(w_off1 + IW'(1));
  assign w_nxtg    = (w_win  == IW'(N - 1))     ? '0 : w_win + IW'(1);

  assign mem_wen_o  = in_wen_i[w_win];
  assign mem_add_o  = in_add_i[w_win];
  assign mem_data_o = in_data_i[w_win];
  assign mem_be_o   = in_be_i[w_win];

  always_comb begin
    in_gnt_o = '0;
    if (mem_req_o) in_gnt_o[w_win] = mem_gnt_i;
  end

  // Only the pointer of the group that produced the winner advances.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_p0 <= '0;
      r_p1 <= '0;
      r_pg <= '0;
    end else if (w_acc) begin
      if (arb_policy_i)   r_pg <= w_nxtg;
      else if (w_win_ch1) r_p1 <= w_nxt1;
      else                r_p0 <= w_nxt0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pv <= '0;
      r_pi <= '0;
    end else begin
      r_pv[0] <= w_acc;
      r_pi[0] <= w_win;
      for (int k = 1; k < MEM_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pi[k] <= r_pi[k-1];
      end
    end
  end

  always_comb begin
    in_r_valid_o = '0;
    in_r_data_o  = '0;
    for (int i = 0; i < N; i++) begin
      if (r_pv[MEM_LAT-1] && (r_pi[MEM_LAT-1] == IW'(i))) begin
        in_r_valid_o[i] = 1'b1;
        in_r_data_o[i]  = mem_r_data_i;
      end
    end
  end

endmodule

// File: tb/tb_hci_l2_bank_arbiter.sv
// Randomized + directed bench for hci_l2_bank_arbiter against a queue/array reference model.
module tb_hci_l2_bank_arbiter;

  localparam int N_CH0 = 4, N_CH1 = 2, N = 6;
  localparam int AW = 32, DW = 32, BW = 8, MEM_LAT = 3, STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst_n, pol, mem_gnt, mem_req, mem_wen;
  logic [N-1:0] req, wen, gnt_o, rv_o;
  logic [N-1:0][AW-1:0] add;
  logic [N-1:0][DW-1:0] wdata, rd_o;
  logic [N-1:0][DW/BW-1:0] be;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_data, mem_rdata;
  logic [DW/BW-1:0] mem_be;

  always #5 clk = ~clk;

  hci_l2_bank_arbiter #(.N_CH0(N_CH0), .N_CH1(N_CH1), .AW(AW), .DW(DW), .BW(BW),
                        .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n), .arb_policy_i(pol),
    .in_req_i(req), .in_wen_i(wen), .in_add_i(add), .in_data_i(wdata), .in_be_i(be),
    .in_gnt_o(gnt_o), .in_r_valid_o(rv_o), .in_r_data_o(rd_o),
    .mem_req_o(mem_req), .mem_wen_o(mem_wen), .mem_add_o(mem_add), .mem_data_o(mem_data),
    .mem_be_o(mem_be), .mem_gnt_i(mem_gnt), .mem_r_data_i(mem_rdata)
  );

  int n_tests = 0, n_fail = 0;
  int m_p0 = 0, m_p1 = 0, m_pg = 0, m_sc = 0, cyc = 0;
  int sched[int];
  bit chk_on = 1'b0;

  task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick_grp(input logic [N-1:0] r, input int base, input int size, input int ptr);
    for (int k = 0; k < size; k++) begin
      if (r[base + (ptr + k) % size]) return base + (ptr + k) % size;
    end
    return -1;
  endfunction

  function automatic int model_win(input logic [N-1:0] r, input logic p);
    int c0, c1;
    bit starve;
    if (p) return pick_grp(r, 0, N, m_pg);
    c0 = pick_grp(r, 0, N_CH0, m_p0);
    c1 = pick_grp(r, N_CH0, N_CH1, m_p1);
`ifdef HCI_L2_ARB_STARVE_EN
    starve = (m_sc >= STARVE_MAX);
`else
    starve = 1'b0;
`endif
    if (c1 >= 0 && (c0 < 0 || starve)) return c1;
    return c0;
  endfunction

  task automatic run_cycle(input logic [N-1:0] r, input logic [N-1:0] we, input logic p,
                           input logic g, input logic rn, input logic [DW-1:0] rdat,
                           output logic [N-1:0] og, output logic [N-1:0] orv,
                           output logic [N-1:0][DW-1:0] ord);
    int w;
    bit acc;
    logic [N-1:0] eg, erv;
    logic [N-1:0][DW-1:0] erd;
    @(posedge clk);
    #1;
    req = r; wen = we; pol = p; mem_gnt = g; rst_n = rn; mem_rdata = rdat;
    for (int i = 0; i < N; i++) begin
      add[i] = $urandom; wdata[i] = $urandom; be[i] = 4'($urandom);
    end
    #4;
    og = gnt_o; orv = rv_o; ord = rd_o;
    w = (|r) ? model_win(r, p) : -1;
    if (chk_on) begin
      chk_eq("mem_req", 256'(mem_req), 256'(|r));
      eg = '0;
      if (w >= 0) eg[w] = g;
      chk_eq("gnt", 256'(gnt_o), 256'(eg));
      if (w >= 0) begin
        chk_eq("mem_add", 256'(mem_add), 256'(add[w]));
        chk_eq("mem_wen", 256'(mem_wen), 256'(we[w]));
        chk_eq("mem_data", 256'(mem_data), 256'(wdata[w]));
        chk_eq("mem_be", 256'(mem_be), 256'(be[w]));
      end
      erv = '0; erd = '0;
      if (sched.exists(cyc)) begin
        erv[sched[cyc]] = 1'b1;
        erd[sched[cyc]] = rdat;
      end
      chk_eq("r_valid", 256'(rv_o), 256'(erv));
      chk_eq("r_data", 256'(rd_o), 256'(erd));
    end
    if (sched.exists(cyc)) sched.delete(cyc);
    if (!rn) begin
      m_p0 = 0; m_p1 = 0; m_pg = 0; m_sc = 0;
      sched.delete();
    end else begin
      acc = (w >= 0) && g;
      if (p || !(|r[N-1:N_CH0])) m_sc = 0;
      else if (acc) m_sc = (w >= N_CH0) ? 0 : ((m_sc < STARVE_MAX) ? m_sc + 1 : m_sc);
      if (acc) begin
        sched[cyc + MEM_LAT] = w;
        if (p)               m_pg = (w + 1) % N;
        else if (w >= N_CH0) m_p1 = (w - N_CH0 + 1) % N_CH1;
        else                 m_p0 = (w + 1) % N_CH0;
      end
    end
    cyc++;
  endtask

  logic [N-1:0] og, orv, eg;
  logic [N-1:0][DW-1:0] ord;

  task automatic do_reset();
    logic [N-1:0] a, b;
    logic [N-1:0][DW-1:0] c;
    run_cycle('0, '0, 1'b0, 1'b0, 1'b0, '0, a, b, c);
  endtask

  initial begin
    logic [N-1:0] r;
    logic p, g, rn;
    int idx;
    run_cycle('0, '0, 1'b0, 1'b0, 1'b0, '0, og, orv, ord);
    chk_on = 1'b1;
    run_cycle('1, '1, 1'b0, 1'b1, 1'b0, '0, og, orv, ord);
    chk_eq("rst_rvalid", 256'(orv), 256'(0));

    // Flat round-robin over all six channels.
    for (int k = 0; k < 7; k++) begin
      run_cycle('1, '0, 1'b1, 1'b1, 1'b1, $urandom, og, orv, ord);
      eg = '0; eg[k % 6] = 1'b1;
      chk_eq("rr_seq", 256'(og), 256'(eg));
    end

    // Starvation of channel 4 behind channel 0.
    do_reset();
    for (int k = 0; k < 27; k++) begin
      run_cycle(6'b010001, '0, 1'b0, 1'b1, 1'b1, $urandom, og, orv, ord);
`ifdef HCI_L2_ARB_STARVE_EN
      idx = (k % 9 == 8) ? 4 : 0;
`else
      idx = 0;
`endif
      eg = '0; eg[idx] = 1'b1;
      chk_eq("starve_seq", 256'(og), 256'(eg));
    end

    // Read latency on channel 2.
    do_reset();
    run_cycle('0, '0, 1'b0, 1'b1, 1'b1, $urandom, og, orv, ord);
    run_cycle(6'b000100, 6'b000100, 1'b0, 1'b1, 1'b1, $urandom, og, orv, ord);
    for (int k = 1; k <= 4; k++) begin
      run_cycle('0, '0, 1'b0, 1'b1, 1'b1, (k == MEM_LAT) ? 32'hCAFE0002 : $urandom, og, orv, ord);
      chk_eq("lat_valid", 256'(orv), (k == MEM_LAT) ? 256'(6'b000100) : 256'(0));
      if (k == MEM_LAT) chk_eq("lat_data", 256'(ord[2]), 256'(32'hCAFE0002));
    end

    // Bank backpressure: no grant while mem_gnt_i is low.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_cycle(6'b001010, '0, 1'b0, 1'b0, 1'b1, $urandom, og, orv, ord);
      chk_eq("bp_gnt", 256'(og), 256'(0));
      chk_eq("bp_rv", 256'(orv), 256'(0));
    end
    run_cycle(6'b001010, '0, 1'b0, 1'b1, 1'b1, $urandom, og, orv, ord);
    chk_eq("bp_first", 256'(og), 256'(6'b000010));

    // Reset drops in-flight response and clears pointers.
    do_reset();
    run_cycle(6'b001000, '1, 1'b1, 1'b1, 1'b1, $urandom, og, orv, ord);
    do_reset();
    for (int k = 0; k <= MEM_LAT; k++) begin
      run_cycle('0, '0, 1'b0, 1'b0, 1'b1, $urandom, og, orv, ord);
      chk_eq("rst_drop", 256'(orv), 256'(0));
    end
    run_cycle('1, '0, 1'b1, 1'b1, 1'b1, $urandom, og, orv, ord);
    chk_eq("rst_ptr", 256'(og), 256'(1));

    // Randomized traffic, policy switches and occasional resets.
    p = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 9) < ((i >= N_CH0) ? 7 : 5));
      if ($urandom_range(0, 19) == 0) p = ~p;
      g  = ($urandom_range(0, 3) != 0);
      rn = ($urandom_range(0, 99) != 0);
      run_cycle(r, N'($urandom), p, g, rn, $urandom, og, orv, ord);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
